// File: rtl/fir_pkg.sv
// fir_pkg: shared FSM state type and arithmetic helpers for the FIR engine
package fir_pkg;
  typedef enum logic [1:0] {IDLE, RUN, FLUSH, OUT} state_t;
  function automatic int acc_width(input int dw, input int cw, input int taps);
    return dw + cw + $clog2(taps);
  endfunction
  function automatic logic signed [63:0] round_sat(input logic signed [63:0] a, input int shift, input int dw);
    logic signed [63:0] r, hi;
    r = (a + (64'sd1 <<< (shift - 1))) >>> shift;
    hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
    return r > hi ? hi : r < -hi - 64'sd1 ? -hi - 64'sd1 : r;
  endfunction
endpackage

// File: rtl/fir_delay_line.sv
// fir_delay_line: circular sample store with one write port and a registered read port
module fir_delay_line #(
  parameter int DATA_WIDTH = 16,
  parameter int TAPS = 32,
  parameter int ADDR_WIDTH = $clog2(TAPS)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         wr_en,
  input  logic [ADDR_WIDTH-1:0]        wr_addr,
  input  logic signed [DATA_WIDTH-1:0] wr_data,
  input  logic [ADDR_WIDTH-1:0]        rd_addr,
  output logic signed [DATA_WIDTH-1:0] rd_data
);
  logic signed [DATA_WIDTH-1:0] mem [TAPS];
  // storage with synchronous clear so unwritten taps read as zero
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < TAPS; i++) mem[i] <= '0;
      rd_data <= '0;
    end else begin
      if (wr_en) mem[wr_addr] <= wr_data;
      rd_data <= mem[rd_addr];
    end
  end
endmodule

// File: rtl/fir_mac_seq.sv
// fir_mac_seq: time-multiplexed FIR, one rounded/saturated output per accepted sample
module fir_mac_seq
  import fir_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int COEF_WIDTH = 16,
  parameter int TAPS = 32,
  parameter int ADDR_WIDTH = $clog2(TAPS),
  parameter int OUT_SHIFT = COEF_WIDTH - 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [DATA_WIDTH-1:0] s_tdata_i,
  input  logic                  s_tvalid_i,
  output logic                  s_tready_o,
  output logic [DATA_WIDTH-1:0] m_tdata_o,
  output logic                  m_tvalid_o,
  input  logic                  m_tready_i,
  output logic [ADDR_WIDTH-1:0] coef_addr_o,
  input  logic [COEF_WIDTH-1:0] coef_data_i
);
  localparam int PW = DATA_WIDTH + COEF_WIDTH;
  localparam int AW = acc_width(DATA_WIDTH, COEF_WIDTH, TAPS);
  state_t state, state_n;
  logic [ADDR_WIDTH-1:0] k, base, wr_ptr;
  logic signed [DATA_WIDTH-1:0] rd_data;
  logic signed [PW-1:0] p;
  logic signed [AW-1:0] acc;
  logic rd_v, p_v, accept;
  assign s_tready_o = state == IDLE && !rst_i;
  assign accept = s_tvalid_i && s_tready_o;
  assign m_tvalid_o = state == OUT;
  assign m_tdata_o = state == OUT ? DATA_WIDTH'(round_sat(64'(acc), OUT_SHIFT, DATA_WIDTH)) : '0;
  assign coef_addr_o = k;
  fir_delay_line #(.DATA_WIDTH(DATA_WIDTH), .TAPS(TAPS), .ADDR_WIDTH(ADDR_WIDTH)) u_delay (
    .clk(clk_i),
    .rst(rst_i),
    .wr_en(accept),
    .wr_addr(wr_ptr),
    .wr_data(s_tdata_i),
    .rd_addr(base - k),
    .rd_data(rd_data)
  );
  // state register
  always_ff @(posedge clk_i) begin
    if (rst_i) state <= IDLE;
    else state <= state_n;
  end
  // next state: RUN issues TAPS addresses, FLUSH drains the two pipeline stages
  always_comb begin
    state_n = state;
    state_n = state == IDLE  ? (accept ? RUN : IDLE)
            : state == RUN   ? (k == ADDR_WIDTH'(TAPS - 1) ? FLUSH : RUN)
            : state == FLUSH ? (k[0] ? OUT : FLUSH)
            :                  (m_tready_i ? IDLE : OUT);
  end
  // tap counter, pointers and the read/multiply/accumulate pipeline
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      k <= '0;
      base <= '0;
      wr_ptr <= '0;
      rd_v <= 1'b0;
      p_v <= 1'b0;
      p <= '0;
      acc <= '0;
    end else begin
      k <= (state_n == state && (state == RUN || state == FLUSH)) ? k + ADDR_WIDTH'(1) : '0;
      base <= accept ? wr_ptr : base;
      wr_ptr <= (state == OUT && m_tready_i) ? wr_ptr + ADDR_WIDTH'(1) : wr_ptr;
      rd_v <= state == RUN;
      p_v <= rd_v;
      p <= rd_data * $signed(coef_data_i);
      acc <= accept ? '0 : p_v ? acc + AW'(p) : acc;
    end
  end
endmodule

// File: tb/tb_fir_mac_seq.sv
// tb_fir_mac_seq: directed and randomized checks of fir_mac_seq against a sample-history model
module tb_fir_mac_seq;
  localparam int TAPS = 4;
  logic clk = 1'b0;
  logic rst_i;
  logic [15:0] s_tdata_i;
  logic s_tvalid_i, s_tready_o;
  logic [15:0] m_tdata_o;
  logic m_tvalid_o, m_tready_i;
  logic [1:0] coef_addr_o;
  logic [15:0] coef_data_i;
  logic [15:0] rom [TAPS];
  int hist [$];
  int checks = 0;
  int failures = 0;
  logic [15:0] got;
  logic seen;
  logic [15:0] imp_in [5] = '{16'h4000, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
  logic [15:0] imp_exp [5] = '{16'h2000, 16'h1000, 16'h0800, 16'h0400, 16'h0000};

  fir_mac_seq #(.TAPS(TAPS)) dut (
    .clk_i(clk),
    .rst_i(rst_i),
    .s_tdata_i(s_tdata_i),
    .s_tvalid_i(s_tvalid_i),
    .s_tready_o(s_tready_o),
    .m_tdata_o(m_tdata_o),
    .m_tvalid_o(m_tvalid_o),
    .m_tready_i(m_tready_i),
    .coef_addr_o(coef_addr_o),
    .coef_data_i(coef_data_i)
  );

  always #5 clk = ~clk;
  always @(posedge clk) coef_data_i <= rom[coef_addr_o];

  function automatic logic [15:0] model();
    longint acc = 0;
    longint r;
    for (int j = 0; j < TAPS; j++)
      if (j < hist.size()) acc += longint'($signed(rom[j])) * longint'(hist[hist.size() - 1 - j]);
    r = (acc + 64'sd16384) >>> 15;
    if (r > 32767) r = 32767;
    if (r < -32768) r = -32768;
    return r[15:0];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    checks++;
    assert (obs === want) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, want);
    end
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    s_tvalid_i = 1'b0;
    m_tready_i = 1'b0;
    @(posedge clk); #1;
    chk("rst_ready_low", 32'(s_tready_o), 32'd0);
    @(posedge clk); #1;
    chk("rst_valid_low", 32'(m_tvalid_o), 32'd0);
    chk("rst_data_zero", 32'(m_tdata_o), 32'd0);
    rst_i = 1'b0;
    hist.delete();
    #1;
    chk("idle_ready", 32'(s_tready_o), 32'd1);
  endtask

  task automatic send(input logic [15:0] x, input int hold, output logic [15:0] res);
    int n;
    logic addr_ok, rdy_low, stable;
    logic [15:0] want;
    n = 0;
    while (!s_tready_o && n < 50) begin @(posedge clk); #1; n++; end
    chk("ready_wait", 32'(s_tready_o), 32'd1);
    s_tdata_i = x;
    s_tvalid_i = 1'b1;
    @(posedge clk); #1;
    hist.push_back(int'($signed(x)));
    want = model();
    n = 1;
    addr_ok = 1'b1;
    rdy_low = 1'b1;
    while (!m_tvalid_o && n < 50) begin
      if (n <= TAPS && coef_addr_o !== 2'(n - 1)) addr_ok = 1'b0;
      if (s_tready_o) rdy_low = 1'b0;
      s_tvalid_i = 1'($urandom);
      s_tdata_i = 16'($urandom);
      @(posedge clk); #1;
      n++;
    end
    if (s_tready_o) rdy_low = 1'b0;
    chk("latency", 32'(n), 32'(TAPS + 3));
    chk("addr_seq", 32'(addr_ok), 32'd1);
    chk("ready_low_busy", 32'(rdy_low), 32'd1);
    res = m_tdata_o;
    stable = 1'b1;
    for (int i = 0; i < hold; i++) begin
      s_tvalid_i = 1'b1;
      s_tdata_i = 16'($urandom);
      @(posedge clk); #1;
      if (m_tdata_o !== res || m_tvalid_o !== 1'b1 || s_tready_o !== 1'b0) stable = 1'b0;
    end
    if (hold > 0) chk("hold_stable", 32'(stable), 32'd1);
    s_tvalid_i = 1'b0;
    m_tready_i = 1'b1;
    chk("out_data", 32'(m_tdata_o), 32'(want));
    @(posedge clk); #1;
    m_tready_i = 1'b0;
    chk("ready_after_xfer", 32'(s_tready_o), 32'd1);
    chk("valid_after_xfer", 32'(m_tvalid_o), 32'd0);
  endtask

  initial begin
    rst_i = 1'b1;
    s_tvalid_i = 1'b0;
    s_tdata_i = '0;
    m_tready_i = 1'b0;
    rom = '{16'h4000, 16'h2000, 16'h1000, 16'h0800};
    repeat (2) @(posedge clk);
    do_reset();
    for (int i = 0; i < 5; i++) begin
      send(imp_in[i], 0, got);
      chk("impulse", 32'(got), 32'(imp_exp[i]));
    end
    send(16'h1234, 10, got);
    do_reset();
    rom = '{16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF};
    for (int i = 0; i < 4; i++) send(16'h7FFF, 0, got);
    chk("sat_pos", 32'(got), 32'h7FFF);
    for (int i = 0; i < 4; i++) send(16'h8000, 0, got);
    chk("sat_neg", 32'(got), 32'h8000);
    do_reset();
    rom = '{16'h0001, 16'h0000, 16'h0000, 16'h0000};
    send(16'h4000, 0, got);
    chk("round_up", 32'(got), 32'h0001);
    send(16'h3FFF, 0, got);
    chk("round_down", 32'(got), 32'h0000);
    do_reset();
    rom = '{16'h4000, 16'h2000, 16'h1000, 16'h0800};
    s_tdata_i = 16'h7000;
    s_tvalid_i = 1'b1;
    @(posedge clk); #1;
    s_tvalid_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_i = 1'b1;
    @(posedge clk); #1;
    rst_i = 1'b0;
    hist.delete();
    seen = 1'b0;
    repeat (15) begin
      @(posedge clk); #1;
      if (m_tvalid_o) seen = 1'b1;
    end
    chk("no_out_after_rst", 32'(seen), 32'd0);
    send(16'h4000, 0, got);
    chk("post_rst_impulse", 32'(got), 32'h2000);
    do_reset();
    for (int j = 0; j < TAPS; j++) rom[j] = 16'($urandom);
    for (int i = 0; i < 12; i++) send(16'($urandom), int'($urandom_range(0, 3)), got);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
